// File: rtl/params_pkg.sv
// params_pkg: shared pipeline parameters and the memory-stage state type.
//   DATA_WIDTH         - data and ALU result width
//   ADDR_WIDTH         - data memory address width
//   REGISTER_WIDTH     - register index width
//   MEM_TIMEOUT_CYCLES - memory-stage watchdog limit (used with MEM_STAGE_TIMEOUT_EN)
package params_pkg;

    localparam int unsigned DATA_WIDTH         = 32;
    localparam int unsigned ADDR_WIDTH         = 16;
    localparam int unsigned REGISTER_WIDTH     = 5;
    localparam int unsigned MEM_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_REQ,
        MEM_WAIT
    } mem_state_t;

endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog: cycle counter for an outstanding data-memory access.
//   clk_i     - clock
//   rst_i     - asynchronous active-low reset
//   start_i   - access is entering MEM_REQ; clears the count
//   active_i  - FSM is in MEM_REQ or MEM_WAIT this cycle
//   expire_o  - this cycle is the TIMEOUT_CYCLES-th cycle of the access (or later)
module mem_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = params_pkg::MEM_TIMEOUT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic active_i,
    output logic expire_o
);

    localparam int unsigned CNT_WIDTH =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (active_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts completed access cycles, so cnt_q == limit-1 marks the limit-th cycle.
    // >= keeps a late expiry from being missed if a load grant pushed past the limit.
    assign expire_o = active_i && (cnt_q >= CNT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage. ALU results pass through in one cycle; loads and
// stores run a req/gnt/rvalid handshake with the data memory while stalling upstream.
// Build option: define MEM_STAGE_TIMEOUT_EN to add the access watchdog (mem_watchdog).
//   clk_i, rst_i                 - clock, asynchronous active-low reset
//   valid_i .. wr_reg_i          - registered ALU-stage outputs
//   stall_o                      - upstream must hold its outputs
//   dmem_*                       - data memory request / response
//   wb_*                         - registered writeback record, one pulse per retirement
//   mem_error_o                  - watchdog timeout pulse (0 without the watchdog)
module mem_stage #(
    parameter int unsigned DATA_WIDTH     = params_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH     = params_pkg::ADDR_WIDTH,
    parameter int unsigned REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = params_pkg::MEM_TIMEOUT_CYCLES
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    input  logic                      reg_wr_en_i,
    input  logic                      is_load_i,
    input  logic                      is_store_i,
    input  logic [DATA_WIDTH-1:0]     alu_result_i,
    input  logic [DATA_WIDTH-1:0]     reg_a_data_i,
    input  logic [REGISTER_WIDTH-1:0] wr_reg_i,
    output logic                      stall_o,
    output logic                      dmem_req_o,
    output logic                      dmem_we_o,
    output logic [ADDR_WIDTH-1:0]     dmem_addr_o,
    output logic [DATA_WIDTH-1:0]     dmem_wdata_o,
    input  logic                      dmem_gnt_i,
    input  logic                      dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata_i,
    output logic                      wb_valid_o,
    output logic                      wb_reg_wr_en_o,
    output logic [REGISTER_WIDTH-1:0] wb_wr_reg_o,
    output logic [DATA_WIDTH-1:0]     wb_data_o,
    output logic                      mem_error_o
);

    import params_pkg::*;

    mem_state_t state_q, state_d;

    // Capture registers for the access in flight.
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic                      we_q, we_d;
    logic [REGISTER_WIDTH-1:0] wr_reg_q, wr_reg_d;
    logic                      reg_wr_en_q, reg_wr_en_d;

    // Writeback record.
    logic                      wb_valid_q, wb_valid_d;
    logic                      wb_reg_wr_en_q, wb_reg_wr_en_d;
    logic [REGISTER_WIDTH-1:0] wb_wr_reg_q, wb_wr_reg_d;
    logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;

    logic err_q, err_d;
    logic mem_op;
    logic start;
    logic expire;

    assign mem_op = is_load_i | is_store_i;
    assign start  = (state_q == MEM_IDLE) && valid_i && mem_op;

`ifdef MEM_STAGE_TIMEOUT_EN
    mem_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_mem_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start),
        .active_i ((state_q == MEM_REQ) || (state_q == MEM_WAIT)),
        .expire_o (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        we_d           = we_q;
        wr_reg_d       = wr_reg_q;
        reg_wr_en_d    = reg_wr_en_q;
        wb_valid_d     = 1'b0;
        wb_reg_wr_en_d = wb_reg_wr_en_q;
        wb_wr_reg_d    = wb_wr_reg_q;
        wb_data_d      = wb_data_q;
        err_d          = 1'b0;
        stall_o        = 1'b0;

        case (state_q)
            MEM_IDLE: begin
                if (valid_i && mem_op) begin
                    addr_d      = alu_result_i[ADDR_WIDTH-1:0];
                    wdata_d     = reg_a_data_i;
                    we_d        = is_store_i;
                    wr_reg_d    = wr_reg_i;
                    reg_wr_en_d = reg_wr_en_i;
                    stall_o     = 1'b1;
                    state_d     = MEM_REQ;
                end else begin
                    wb_valid_d     = valid_i;
                    wb_reg_wr_en_d = valid_i & reg_wr_en_i;
                    wb_data_d      = alu_result_i;
                    wb_wr_reg_d    = wr_reg_i;
                end
            end
            MEM_REQ: begin
                stall_o = ~(dmem_gnt_i & we_q) & ~expire;
                // A grant is progress and takes priority over a same-cycle expiry.
                if (dmem_gnt_i) begin
                    if (we_q) begin
                        wb_valid_d     = 1'b1;
                        wb_reg_wr_en_d = 1'b0;
                        wb_wr_reg_d    = wr_reg_q;
                        state_d        = MEM_IDLE;
                    end else begin
                        state_d = MEM_WAIT;
                    end
                end else if (expire) begin
                    wb_valid_d     = 1'b1;
                    wb_reg_wr_en_d = 1'b0;
                    wb_wr_reg_d    = wr_reg_q;
                    err_d          = 1'b1;
                    state_d        = MEM_IDLE;
                end
            end
            MEM_WAIT: begin
                stall_o = ~dmem_rvalid_i & ~expire;
                if (dmem_rvalid_i) begin
                    wb_valid_d     = 1'b1;
                    wb_reg_wr_en_d = reg_wr_en_q;
                    wb_wr_reg_d    = wr_reg_q;
                    wb_data_d      = dmem_rdata_i;
                    state_d        = MEM_IDLE;
                end else if (expire) begin
                    wb_valid_d     = 1'b1;
                    wb_reg_wr_en_d = 1'b0;
                    wb_wr_reg_d    = wr_reg_q;
                    err_d          = 1'b1;
                    state_d        = MEM_IDLE;
                end
            end
            default: begin
                state_d = MEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q        <= MEM_IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            we_q           <= 1'b0;
            wr_reg_q       <= '0;
            reg_wr_en_q    <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_reg_wr_en_q <= 1'b0;
            wb_wr_reg_q    <= '0;
            wb_data_q      <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            we_q           <= we_d;
            wr_reg_q       <= wr_reg_d;
            reg_wr_en_q    <= reg_wr_en_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_wr_en_q <= wb_reg_wr_en_d;
            wb_wr_reg_q    <= wb_wr_reg_d;
            wb_data_q      <= wb_data_d;
            err_q          <= err_d;
        end
    end

    // req comes straight from the state so an async reset drops it immediately.
    assign dmem_req_o     = (state_q == MEM_REQ);
    assign dmem_we_o      = we_q;
    assign dmem_addr_o    = addr_q;
    assign dmem_wdata_o   = wdata_q;
    assign wb_valid_o     = wb_valid_q;
    assign wb_reg_wr_en_o = wb_reg_wr_en_q;
    assign wb_wr_reg_o    = wb_wr_reg_q;
    assign wb_data_o      = wb_data_q;
    assign mem_error_o    = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_stage;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 4;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i, reg_wr_en_i, is_load_i, is_store_i;
    logic [31:0] alu_result_i, reg_a_data_i;
    logic [4:0]  wr_reg_i;
    logic        stall_o, dmem_req_o, dmem_we_o;
    logic [15:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o, wb_reg_wr_en_o;
    logic [4:0]  wb_wr_reg_o;
    logic [31:0] wb_data_o;
    logic        mem_error_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    mem_stage #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (16),
        .REGISTER_WIDTH (5),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .reg_wr_en_i    (reg_wr_en_i),
        .is_load_i      (is_load_i),
        .is_store_i     (is_store_i),
        .alu_result_i   (alu_result_i),
        .reg_a_data_i   (reg_a_data_i),
        .wr_reg_i       (wr_reg_i),
        .stall_o        (stall_o),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_wdata_o   (dmem_wdata_o),
        .dmem_gnt_i     (dmem_gnt_i),
        .dmem_rvalid_i  (dmem_rvalid_i),
        .dmem_rdata_i   (dmem_rdata_i),
        .wb_valid_o     (wb_valid_o),
        .wb_reg_wr_en_o (wb_reg_wr_en_o),
        .wb_wr_reg_o    (wb_wr_reg_o),
        .wb_data_o      (wb_data_o),
        .mem_error_o    (mem_error_o)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: observed running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        rst_i         = 1'b0;
        valid_i       = 1'b0;
        reg_wr_en_i   = 1'b0;
        is_load_i     = 1'b0;
        is_store_i    = 1'b0;
        alu_result_i  = '0;
        reg_a_data_i  = '0;
        wr_reg_i      = '0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
        #1;
        chk1("rst_wb_valid", wb_valid_o, 1'b0);
        chk1("rst_wb_wren", wb_reg_wr_en_o, 1'b0);
        chkw("rst_wb_data", wb_data_o, 32'h0);
        chkw("rst_wb_reg", 32'(wb_wr_reg_o), 32'h0);
        chk1("rst_req", dmem_req_o, 1'b0);
        chk1("rst_stall", stall_o, 1'b0);
        chk1("rst_err", mem_error_o, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // ALU pass-through
        valid_i = 1'b1; reg_wr_en_i = 1'b1; alu_result_i = 32'h1234; wr_reg_i = 5'd5;
        #1 chk1("alu_stall_pre", stall_o, 1'b0);
        @(negedge clk_i);
        chk1("alu_wb_valid", wb_valid_o, 1'b1);
        chkw("alu_wb_data", wb_data_o, 32'h1234);
        chkw("alu_wb_reg", 32'(wb_wr_reg_o), 32'd5);
        chk1("alu_wb_wren", wb_reg_wr_en_o, 1'b1);
        chk1("alu_stall_post", stall_o, 1'b0);

        // Spurious rvalid in MEM_IDLE during an ALU op
        alu_result_i = 32'h7777; wr_reg_i = 5'd3; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h5555;
        step();
        chkw("spur_wb_data", wb_data_o, 32'h7777);
        chk1("spur_wb_valid", wb_valid_o, 1'b1);
        dmem_rvalid_i = 1'b0; valid_i = 1'b0;
        step();
        chk1("idle_wb_valid", wb_valid_o, 1'b0);
        chk1("idle_wb_wren", wb_reg_wr_en_o, 1'b0);

        // Store 0xDEAD to 0x40, gnt after two wait cycles
        valid_i = 1'b1; is_store_i = 1'b1; reg_wr_en_i = 1'b0;
        alu_result_i = 32'h40; reg_a_data_i = 32'hDEAD; wr_reg_i = 5'd0;
        #1;
        chk1("st_stall_idle", stall_o, 1'b1);
        chk1("st_req_idle", dmem_req_o, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            chk1("st_req", dmem_req_o, 1'b1);
            chk1("st_we", dmem_we_o, 1'b1);
            chkw("st_addr", 32'(dmem_addr_o), 32'h40);
            chkw("st_wdata", dmem_wdata_o, 32'hDEAD);
            chk1("st_wb_valid_stall", wb_valid_o, 1'b0);
            if (i == 2) dmem_gnt_i = 1'b1;
            #1 chk1("st_stall", stall_o, (i == 2) ? 1'b0 : 1'b1);
        end
        step();
        dmem_gnt_i = 1'b0; valid_i = 1'b0; is_store_i = 1'b0;
        chk1("st_wb_valid", wb_valid_o, 1'b1);
        chk1("st_wb_wren", wb_reg_wr_en_o, 1'b0);
        chk1("st_req_done", dmem_req_o, 1'b0);
        step();
        chk1("st_wb_pulse", wb_valid_o, 1'b0);

        // Load from 0x80, immediate gnt, rvalid three cycles later
        valid_i = 1'b1; is_load_i = 1'b1; reg_wr_en_i = 1'b1;
        alu_result_i = 32'h80; wr_reg_i = 5'd7; dmem_gnt_i = 1'b1;
        step();
        chk1("ld_req", dmem_req_o, 1'b1);
        chk1("ld_we", dmem_we_o, 1'b0);
        chkw("ld_addr", 32'(dmem_addr_o), 32'h80);
        chk1("ld_stall_req", stall_o, 1'b1);
        step();
        dmem_gnt_i = 1'b0;
        chk1("ld_req_wait", dmem_req_o, 1'b0);
        chk1("ld_stall_w1", stall_o, 1'b1);
        chk1("ld_wb_valid_w1", wb_valid_o, 1'b0);
        step();
        chk1("ld_stall_w2", stall_o, 1'b1);
        step();
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hBEEF;
        #1 chk1("ld_stall_rvalid", stall_o, 1'b0);
        step();
        dmem_rvalid_i = 1'b0; valid_i = 1'b0; is_load_i = 1'b0;
        chk1("ld_wb_valid", wb_valid_o, 1'b1);
        chkw("ld_wb_data", wb_data_o, 32'hBEEF);
        chkw("ld_wb_reg", 32'(wb_wr_reg_o), 32'd7);
        chk1("ld_wb_wren", wb_reg_wr_en_o, 1'b1);
        step();
        chk1("ld_wb_pulse", wb_valid_o, 1'b0);

        // Reset asserted while waiting for rvalid
        valid_i = 1'b1; is_load_i = 1'b1; alu_result_i = 32'h90; wr_reg_i = 5'd9;
        dmem_gnt_i = 1'b1;
        step();
        step();
        dmem_gnt_i = 1'b0;
        chk1("rw_in_wait", stall_o, 1'b1);
        rst_i = 1'b0; valid_i = 1'b0; is_load_i = 1'b0; alu_result_i = '0; wr_reg_i = '0;
        #1;
        chk1("rw_req", dmem_req_o, 1'b0);
        chk1("rw_wb_valid", wb_valid_o, 1'b0);
        chkw("rw_wb_data", wb_data_o, 32'h0);
        chkw("rw_wb_reg", 32'(wb_wr_reg_o), 32'h0);
        chkw("rw_addr", 32'(dmem_addr_o), 32'h0);
        step();
        rst_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1111;
        step();
        dmem_rvalid_i = 1'b0;
        chk1("rw_late_wb_valid", wb_valid_o, 1'b0);
        chkw("rw_late_wb_data", wb_data_o, 32'h0);
        chk1("rw_late_stall", stall_o, 1'b0);
        valid_i = 1'b1; reg_wr_en_i = 1'b1; alu_result_i = 32'h42; wr_reg_i = 5'd2;
        #1 chk1("rw_idle_stall", stall_o, 1'b0);
        step();
        chk1("rw_idle_wb_valid", wb_valid_o, 1'b1);
        chkw("rw_idle_wb_data", wb_data_o, 32'h42);

`ifdef MEM_STAGE_TIMEOUT_EN
        // Store that is never granted: four REQ cycles then a squashed retirement
        valid_i = 1'b1; is_store_i = 1'b1; reg_wr_en_i = 1'b1; alu_result_i = 32'h44;
        step();
        for (int i = 0; i < 4; i++) begin
            chk1("to_req", dmem_req_o, 1'b1);
            chk1("to_err_early", mem_error_o, 1'b0);
            chk1("to_stall", stall_o, (i == 3) ? 1'b0 : 1'b1);
            if (i < 3) step();
        end
        step();
        valid_i = 1'b0; is_store_i = 1'b0;
        chk1("to_err", mem_error_o, 1'b1);
        chk1("to_wb_valid", wb_valid_o, 1'b1);
        chk1("to_wb_wren", wb_reg_wr_en_o, 1'b0);
        chk1("to_req_drop", dmem_req_o, 1'b0);
        step();
        chk1("to_err_pulse", mem_error_o, 1'b0);
        chk1("to_idle_stall", stall_o, 1'b0);
`else
        chk1("no_wdog_err", mem_error_o, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
